// File: rtl/knn_distance_sequencer.sv
// Job sequencer for the KNN distance datapath: streams query/sample element pairs with
// credit-based issue and buffers index-tagged results. Define MIN_TRACK_EN for minimum tracking.
module knn_distance_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIMENSIONS = 32,
    parameter int unsigned VAL_WIDTH  = 32,
    parameter int unsigned IDX_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [IDX_WIDTH-1:0]          num_samples,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(DIMENSIONS)-1:0] query_addr,
    input  logic [DATA_WIDTH-1:0]         query_data,
    output logic [ADDR_WIDTH-1:0]         sample_addr,
    input  logic [DATA_WIDTH-1:0]         sample_data,
    output logic                          calc_reset,
    output logic                          calc_valid,
    output logic [DATA_WIDTH-1:0]         calc_data1,
    output logic [DATA_WIDTH-1:0]         calc_data2,
    input  logic [VAL_WIDTH-1:0]          calc_distance,
    input  logic                          calc_distance_valid,
    output logic [VAL_WIDTH-1:0]          res_distance,
    output logic [IDX_WIDTH-1:0]          res_index,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [VAL_WIDTH-1:0]          min_distance,
    output logic [IDX_WIDTH-1:0]          min_index
);

    localparam int unsigned DIM_W = $clog2(DIMENSIONS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1) + 2;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StIssue,
        StWaitCredit,
        StDrain,
        StFinish
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;

    logic [IDX_WIDTH-1:0]   r_num;
    logic [IDX_WIDTH-1:0]   r_sample;
    logic [DIM_W-1:0]       r_dim;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic                   r_calc_valid;
    logic [CNT_W-1:0]       r_in_flight;

    logic [IDX_WIDTH-1:0]   r_tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_tag_wp;
    logic [PTR_W-1:0]       r_tag_rp;

    logic [VAL_WIDTH-1:0]   r_res_dist [FIFO_DEPTH];
    logic [IDX_WIDTH-1:0]   r_res_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_res_wp;
    logic [PTR_W-1:0]       r_res_rp;
    logic [CNT_W-1:0]       r_fifo_count;

    logic                   w_issue;
    logic                   w_last_dim;
    logic                   w_last_sample;
    logic                   w_vec_end;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_res_valid;
    logic [CNT_W-1:0]       w_occ;
    logic                   w_credit_now;
    logic                   w_credit_next;
    logic [IDX_WIDTH-1:0]   w_tag_head;

    assign w_issue       = (r_state == StIssue);
    assign w_last_dim    = (r_dim == DIM_W'(DIMENSIONS - 1));
    assign w_last_sample = (r_sample == r_num - IDX_WIDTH'(1));
    assign w_vec_end     = w_issue & w_last_dim;
    // Results only arrive for vectors we issued; anything else is stale datapath output.
    assign w_push        = calc_distance_valid & (r_in_flight != '0);
    assign w_res_valid   = (r_fifo_count != '0);
    assign w_pop         = w_res_valid & res_ready;
    assign w_tag_head    = r_tag_mem[r_tag_rp];

    // Occupancy counts results buffered plus results still owed by the datapath.
    assign w_occ         = r_fifo_count + r_in_flight;
    assign w_credit_now  = (w_occ + CNT_W'(1)) <= CNT_W'(FIFO_DEPTH);
    assign w_credit_next = (w_occ + CNT_W'(2)) <= (CNT_W'(FIFO_DEPTH) + CNT_W'(w_pop));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StClear;
                end
            end
            StClear: begin
                w_state_next = (r_num == '0) ? StFinish : StIssue;
            end
            StIssue: begin
                if (w_vec_end) begin
                    if (w_last_sample) begin
                        w_state_next = StDrain;
                    end else if (!w_credit_next) begin
                        w_state_next = StWaitCredit;
                    end
                end
            end
            StWaitCredit: begin
                if (w_credit_now) begin
                    w_state_next = StIssue;
                end
            end
            StDrain: begin
                if ((r_in_flight == '0) && (r_fifo_count == '0)) begin
                    w_state_next = StFinish;
                end
            end
            StFinish: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_num        <= '0;
            r_sample     <= '0;
            r_dim        <= '0;
            r_base       <= '0;
            r_calc_valid <= 1'b0;
            r_in_flight  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_calc_valid <= w_issue;
            if ((r_state == StIdle) && start) begin
                r_num <= num_samples;
            end
            if (r_state == StClear) begin
                r_sample <= '0;
                r_dim    <= '0;
                r_base   <= '0;
            end else if (w_issue) begin
                if (w_last_dim) begin
                    r_dim    <= '0;
                    r_sample <= r_sample + IDX_WIDTH'(1);
                    r_base   <= r_base + ADDR_WIDTH'(DIMENSIONS);
                end else begin
                    r_dim <= r_dim + DIM_W'(1);
                end
            end
            r_in_flight <= r_in_flight + CNT_W'(w_vec_end) - CNT_W'(w_push);
        end
    end

    // Index tag queue: one entry per vector awaiting its distance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_wp <= '0;
            r_tag_rp <= '0;
        end else begin
            if (w_vec_end) begin
                r_tag_wp <= r_tag_wp + PTR_W'(1);
            end
            if (w_push) begin
                r_tag_rp <= r_tag_rp + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_vec_end) begin
            r_tag_mem[r_tag_wp] <= r_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_wp     <= '0;
            r_res_rp     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_res_wp <= r_res_wp + PTR_W'(1);
            end
            if (w_pop) begin
                r_res_rp <= r_res_rp + PTR_W'(1);
            end
            r_fifo_count <= r_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_res_dist[r_res_wp] <= calc_distance;
            r_res_idx[r_res_wp]  <= w_tag_head;
        end
    end

`ifdef MIN_TRACK_EN
    logic [VAL_WIDTH-1:0] r_min_dist;
    logic [IDX_WIDTH-1:0] r_min_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_min_dist <= '0;
            r_min_idx  <= '0;
        end else if (r_state == StClear) begin
            r_min_dist <= '1;
            r_min_idx  <= '0;
        end else if (w_push && (calc_distance < r_min_dist)) begin
            r_min_dist <= calc_distance;
            r_min_idx  <= w_tag_head;
        end
    end

    assign min_distance = r_min_dist;
    assign min_index    = r_min_idx;
`else
    assign min_distance = '0;
    assign min_index    = '0;
`endif

    assign busy         = (r_state == StClear) || (r_state == StIssue) ||
                          (r_state == StWaitCredit) || (r_state == StDrain);
    assign done         = (r_state == StFinish);
    assign calc_reset   = (r_state == StClear);
    assign query_addr   = r_dim;
    assign sample_addr  = r_base + ADDR_WIDTH'(r_dim);
    // RAM read data lines up with calc_valid; gated so idle outputs stay at zero.
    assign calc_valid   = r_calc_valid;
    assign calc_data1   = r_calc_valid ? query_data : '0;
    assign calc_data2   = r_calc_valid ? sample_data : '0;
    assign res_valid    = w_res_valid;
    assign res_distance = w_res_valid ? r_res_dist[r_res_rp] : '0;
    assign res_index    = w_res_valid ? r_res_idx[r_res_rp] : '0;

endmodule

// File: tb/tb_knn_distance_sequencer.sv
// Directed self-checking bench for knn_distance_sequencer with behavioural RAMs and a
// squared-Euclidean datapath model.
`timescale 1ns/1ps
module tb_knn_distance_sequencer;

    localparam int DW   = 32;
    localparam int DIMS = 4;
    localparam int VW   = 32;
    localparam int IW   = 16;
    localparam int AW   = 21;
    localparam int FD   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] num_samples;
    logic          busy;
    logic          done;
    logic [1:0]    query_addr;
    logic [DW-1:0] query_data;
    logic [AW-1:0] sample_addr;
    logic [DW-1:0] sample_data;
    logic          calc_reset;
    logic          calc_valid;
    logic [DW-1:0] calc_data1;
    logic [DW-1:0] calc_data2;
    logic [VW-1:0] calc_distance;
    logic          calc_distance_valid;
    logic [VW-1:0] res_distance;
    logic [IW-1:0] res_index;
    logic          res_valid;
    logic          res_ready;
    logic [VW-1:0] min_distance;
    logic [IW-1:0] min_index;

    knn_distance_sequencer #(
        .DATA_WIDTH (DW),
        .DIMENSIONS (DIMS),
        .VAL_WIDTH  (VW),
        .IDX_WIDTH  (IW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .num_samples         (num_samples),
        .busy                (busy),
        .done                (done),
        .query_addr          (query_addr),
        .query_data          (query_data),
        .sample_addr         (sample_addr),
        .sample_data         (sample_data),
        .calc_reset          (calc_reset),
        .calc_valid          (calc_valid),
        .calc_data1          (calc_data1),
        .calc_data2          (calc_data2),
        .calc_distance       (calc_distance),
        .calc_distance_valid (calc_distance_valid),
        .res_distance        (res_distance),
        .res_index           (res_index),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .min_distance        (min_distance),
        .min_index           (min_index)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] query_mem  [4];
    logic [DW-1:0] sample_mem [64];

    always @(posedge clk) begin
        query_data  <= query_mem[query_addr];
        sample_data <= sample_mem[sample_addr[5:0]];
    end

    // Datapath model: accumulate squared differences per vector, emit after 3 stages.
    logic signed [DW-1:0] dp_diff;
    logic [VW-1:0]        dp_sq;
    logic [VW-1:0]        dp_acc;
    logic [1:0]           dp_cnt;
    logic [2:0]           dp_v;
    logic [VW-1:0]        dp_d0, dp_d1, dp_d2;

    assign dp_diff             = $signed(calc_data1) - $signed(calc_data2);
    assign dp_sq               = dp_diff * dp_diff;
    assign calc_distance       = dp_d2;
    assign calc_distance_valid = dp_v[2];

    always @(posedge clk) begin
        if (reset || calc_reset) begin
            dp_acc <= '0;
            dp_cnt <= '0;
            dp_v   <= '0;
            dp_d0  <= '0;
            dp_d1  <= '0;
            dp_d2  <= '0;
        end else begin
            dp_v[0] <= 1'b0;
            if (calc_valid) begin
                if (dp_cnt == 2'd3) begin
                    dp_d0   <= dp_acc + dp_sq;
                    dp_v[0] <= 1'b1;
                    dp_acc  <= '0;
                    dp_cnt  <= '0;
                end else begin
                    dp_acc <= dp_acc + dp_sq;
                    dp_cnt <= dp_cnt + 2'd1;
                end
            end
            dp_v[1] <= dp_v[0];
            dp_v[2] <= dp_v[1];
            dp_d1   <= dp_d0;
            dp_d2   <= dp_d1;
        end
    end

    int            n_valid  = 0;
    int            n_done   = 0;
    int            n_creset = 0;
    int            n_over   = 0;
    int            occ      = 0;
    logic [VW-1:0] q_d[$];
    logic [IW-1:0] q_i[$];

    always @(posedge clk) begin
        if (calc_valid) n_valid <= n_valid + 1;
        if (done) n_done <= n_done + 1;
        if (calc_reset) n_creset <= n_creset + 1;
        if (res_valid && res_ready) begin
            q_d.push_back(res_distance);
            q_i.push_back(res_index);
        end
        if (reset) begin
            occ <= 0;
        end else begin
            if (calc_distance_valid && !(res_valid && res_ready) && occ >= FD)
                n_over <= n_over + 1;
            occ <= occ + (calc_distance_valid ? 1 : 0) - ((res_valid && res_ready) ? 1 : 0);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic pulse_start(input logic [IW-1:0] n);
        @(negedge clk);
        start       = 1'b1;
        num_samples = n;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic load_basic();
        for (int j = 0; j < 4; j++) begin
            query_mem[j]      = DW'(j + 1);
            sample_mem[j]     = DW'(j + 1);
            sample_mem[4 + j] = '0;
            sample_mem[8 + j] = DW'(5);
        end
    endtask

    task automatic load_ramp();
        for (int j = 0; j < 4; j++) query_mem[j] = DW'(j + 1);
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 4; j++) sample_mem[4 * k + j] = DW'(k);
    endtask

    int            b_valid, b_done, b_res, b_creset;
    bit            hit;
    logic [VW-1:0] exp_ramp [8];

    initial begin
        exp_ramp = '{30, 14, 6, 6, 14, 30, 54, 86};
        reset       = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        res_ready   = 1'b1;
        for (int i = 0; i < 64; i++) sample_mem[i] = '0;
        for (int j = 0; j < 4; j++) query_mem[j] = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_ctrl", {busy, done, calc_valid, calc_reset, res_valid}, 5'b0);
        chk("rst_addr", {query_addr, sample_addr}, '0);
        chk("rst_data", {calc_data1, calc_data2}, '0);
        chk("rst_res", {res_distance, res_index}, '0);
        chk("rst_min", {min_distance, min_index}, '0);
        reset = 1'b0;

        // Basic three-vector job.
        load_basic();
        b_valid = n_valid; b_done = n_done; b_res = q_d.size();
        pulse_start(IW'(3));
        wait_done("t1_done_seen", 200);
        @(negedge clk);
        chk("t1_valid_cycles", 64'(n_valid - b_valid), 64'd12);
        chk("t1_done_pulses", 64'(n_done - b_done), 64'd1);
        chk("t1_nres", 64'(q_d.size() - b_res), 64'd3);
        chk("t1_r0", {q_d[b_res], q_i[b_res]}, {32'd0, 16'd0});
        chk("t1_r1", {q_d[b_res + 1], q_i[b_res + 1]}, {32'd30, 16'd1});
        chk("t1_r2", {q_d[b_res + 2], q_i[b_res + 2]}, {32'd30, 16'd2});

        // Zero-sample job.
        b_valid = n_valid;
        @(negedge clk);
        start = 1'b1; num_samples = '0;
        @(negedge clk);
        start = 1'b0;
        chk("t3_clear_cycle", {calc_reset, busy, done}, 3'b110);
        @(negedge clk);
        chk("t3_done_cycle", {calc_reset, busy, done}, 3'b001);
        @(negedge clk);
        chk("t3_after", {64'(n_valid - b_valid), 1'b0, done}, '0);

        // Backpressure: credit stalls issue after four vectors.
        load_ramp();
        res_ready = 1'b0;
        b_valid = n_valid; b_done = n_done; b_res = q_d.size();
        pulse_start(IW'(8));
        repeat (80) @(negedge clk);
        chk("t2_stall_valid", 64'(n_valid - b_valid), 64'd16);
        chk("t2_stall_state", {busy, res_valid, calc_valid}, 3'b110);
        chk("t2_stall_head", {res_distance, res_index}, {32'd30, 16'd0});
        res_ready = 1'b1;
        wait_done("t2_done_seen", 400);
        @(negedge clk);
        chk("t2_nres", 64'(q_d.size() - b_res), 64'd8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t2_r%0d", k), {q_d[b_res + k], q_i[b_res + k]},
                {exp_ramp[k], 16'(k)});
        chk("t2_overflow", 64'(n_over), 64'd0);
        chk("t2_done_pulses", 64'(n_done - b_done), 64'd1);

        // Reset in the middle of sample 2.
        load_basic();
        b_done = n_done;
        pulse_start(IW'(3));
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy && sample_addr == AW'(9)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t4_reached_s2", 64'(hit), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_ctrl_zero", {busy, done, calc_valid, calc_reset, res_valid}, 5'b0);
        chk("t4_addr_zero", {query_addr, sample_addr}, '0);
        chk("t4_data_zero", {calc_data1, calc_data2, res_distance, res_index}, '0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_no_done", 64'(n_done - b_done), 64'd0);
        b_res = q_d.size();
        pulse_start(IW'(3));
        wait_done("t4_rerun_done", 200);
        @(negedge clk);
        chk("t4_nres", 64'(q_d.size() - b_res), 64'd3);
        chk("t4_r0", {q_d[b_res], q_i[b_res]}, {32'd0, 16'd0});
        chk("t4_r2", {q_d[b_res + 2], q_i[b_res + 2]}, {32'd30, 16'd2});

        // Start while busy and on the done cycle is ignored.
        load_ramp();
        b_done = n_done; b_res = q_d.size(); b_creset = n_creset;
        pulse_start(IW'(2));
        repeat (3) @(negedge clk);
        start = 1'b1; num_samples = IW'(7);
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_done_seen", 200);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_idle_after", {busy, done}, 2'b00);
        chk("t5_one_clear", 64'(n_creset - b_creset), 64'd1);
        chk("t5_one_done", 64'(n_done - b_done), 64'd1);
        chk("t5_nres", 64'(q_d.size() - b_res), 64'd2);
        chk("t5_r1", {q_d[b_res + 1], q_i[b_res + 1]}, {32'd14, 16'd1});

        // Running minimum with a tie: distances 9,4,4,7.
        for (int j = 0; j < 4; j++) query_mem[j] = '0;
        for (int i = 0; i < 16; i++) sample_mem[i] = '0;
        sample_mem[0]  = DW'(3);
        sample_mem[4]  = DW'(2);
        sample_mem[9]  = DW'(2);
        sample_mem[12] = DW'(2);
        sample_mem[13] = DW'(1);
        sample_mem[14] = DW'(1);
        sample_mem[15] = DW'(1);
        b_res = q_d.size();
        pulse_start(IW'(4));
        wait_done("t6_done_seen", 200);
`ifdef MIN_TRACK_EN
        chk("t6_min", {min_distance, min_index}, {32'd4, 16'd1});
`else
        chk("t6_min_off", {min_distance, min_index}, '0);
`endif
        @(negedge clk);
        chk("t6_r3", {q_d[b_res + 3], q_i[b_res + 3]}, {32'd7, 16'd3});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
